// File: rtl/aes_dec_ctrl_if.sv
// Handshake and control bundle between the AES decryption controller,
// the key expansion unit, the round datapath and the surrounding logic.
interface aes_dec_ctrl_if;
  logic       key_load_i;
  logic       kexp_start_o;
  logic       kexp_ready_i;
  logic       text_valid_i;
  logic       text_ready_o;
  logic       dp_load_o;
  logic       dp_en_o;
  logic       dp_last_o;
  logic [3:0] round_num_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       key_valid_o;
  logic       key_reject_o;
  logic       err_o;

  // Controller side
  modport master (
    input  key_load_i, kexp_ready_i, text_valid_i, out_ready_i,
    output kexp_start_o, text_ready_o, dp_load_o, dp_en_o, dp_last_o,
           round_num_o, out_valid_o, key_valid_o, key_reject_o, err_o
  );

  // Environment side (key expansion, datapath, upstream/downstream)
  modport slave (
    output key_load_i, kexp_ready_i, text_valid_i, out_ready_i,
    input  kexp_start_o, text_ready_o, dp_load_o, dp_en_o, dp_last_o,
           round_num_o, out_valid_o, key_valid_o, key_reject_o, err_o
  );
endinterface

// File: rtl/aes_dec_ctrl.sv
// AES decryption sequencer: runs key expansion (with timeout), accepts one
// ciphertext block at a time and steps the datapath through the initial
// AddRoundKey plus NUM_ROUNDS inverse rounds, then holds the plaintext
// until downstream takes it.
module aes_dec_ctrl #(
  parameter int NUM_ROUNDS     = 10,
  parameter int KEYGEN_TIMEOUT = 15
) (
  input logic           clk_i,
  input logic           rst_i,
  aes_dec_ctrl_if.master bus
);

  localparam int         TMO_W    = $clog2(KEYGEN_TIMEOUT + 1);
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(KEYGEN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    KEYGEN,
    READY,
    ROUND,
    OUT
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       rnd_cnt, rnd_cnt_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             key_valid, key_valid_nxt;
  logic             err, err_nxt;

  logic       kexp_start;
  logic       text_ready;
  logic       dp_load;
  logic       dp_en;
  logic       dp_last;
  logic [3:0] round_num;
  logic       out_valid;
  logic       key_reject;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Round counter, keygen timeout counter and the key-valid / error flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rnd_cnt   <= '0;
      tmo_cnt   <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      rnd_cnt   <= rnd_cnt_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
      key_valid <= key_valid_nxt;
      err       <= err_nxt;
    end
  end

  // Next-state and output decode; everything is forced low while in reset
  always_comb begin
    state_nxt     = state;
    rnd_cnt_nxt   = rnd_cnt;
    tmo_cnt_nxt   = tmo_cnt;
    key_valid_nxt = key_valid;
    err_nxt       = err;
    kexp_start    = 1'b0;
    text_ready    = 1'b0;
    dp_load       = 1'b0;
    dp_en         = 1'b0;
    dp_last       = 1'b0;
    round_num     = 4'd0;
    out_valid     = 1'b0;
    key_reject    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.key_load_i) begin
          kexp_start    = 1'b1;
          state_nxt     = KEYGEN;
          key_valid_nxt = 1'b0;
          tmo_cnt_nxt   = '0;
          err_nxt       = 1'b0;
        end
      end

      KEYGEN: begin
        key_reject = bus.key_load_i;
        if (bus.kexp_ready_i) begin
          state_nxt     = READY;
          key_valid_nxt = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
      end

      READY: begin
        // A key load takes priority over a pending ciphertext block
        text_ready = !bus.key_load_i;
        if (bus.key_load_i) begin
          kexp_start    = 1'b1;
          state_nxt     = KEYGEN;
          key_valid_nxt = 1'b0;
          tmo_cnt_nxt   = '0;
          err_nxt       = 1'b0;
        end else if (bus.text_valid_i) begin
          dp_load     = 1'b1;
          state_nxt   = ROUND;
          rnd_cnt_nxt = 4'd0;
        end
      end

      ROUND: begin
        // rnd_cnt holds rounds already done, so the key index is one ahead;
        // it stops at NUM_ROUNDS-1 and therefore never wraps
        key_reject = bus.key_load_i;
        dp_en      = 1'b1;
        round_num  = rnd_cnt + 4'd1;
        dp_last    = (round_num == LAST_RND);
        if (dp_last) state_nxt = OUT;
        else         rnd_cnt_nxt = rnd_cnt + 4'd1;
      end

      OUT: begin
        key_reject = bus.key_load_i;
        out_valid  = 1'b1;
        if (bus.out_ready_i) state_nxt = READY;
      end

      default: state_nxt = IDLE;
    endcase

    if (rst_i) begin
      kexp_start = 1'b0;
      text_ready = 1'b0;
      dp_load    = 1'b0;
      dp_en      = 1'b0;
      dp_last    = 1'b0;
      round_num  = 4'd0;
      out_valid  = 1'b0;
      key_reject = 1'b0;
    end
  end

  assign bus.kexp_start_o = kexp_start;
  assign bus.text_ready_o = text_ready;
  assign bus.dp_load_o    = dp_load;
  assign bus.dp_en_o      = dp_en;
  assign bus.dp_last_o    = dp_last;
  assign bus.round_num_o  = round_num;
  assign bus.out_valid_o  = out_valid;
  assign bus.key_reject_o = key_reject;
  assign bus.key_valid_o  = key_valid && !rst_i;
  assign bus.err_o        = err && !rst_i;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Directed bench for aes_dec_ctrl (NUM_ROUNDS=10, KEYGEN_TIMEOUT=15).
module tb_aes_dec_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_dec_ctrl_if bus();

  aes_dec_ctrl #(
    .NUM_ROUNDS    (10),
    .KEYGEN_TIMEOUT(15)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {bus.round_num_o, bus.kexp_start_o, bus.text_ready_o, bus.dp_load_o,
            bus.dp_en_o, bus.dp_last_o, bus.out_valid_o, bus.key_valid_o,
            bus.key_reject_o, bus.err_o};
  endfunction

  // Drive one cycle's inputs just after the falling edge; outputs are
  // then stable for sampling before the next rising edge.
  task automatic cyc(input logic r, input logic kl, input logic tv,
                     input logic kr, input logic orr);
    @(negedge clk);
    rst              = r;
    bus.key_load_i   = kl;
    bus.text_valid_i = tv;
    bus.kexp_ready_i = kr;
    bus.out_ready_i  = orr;
    #1;
  endtask

  // Key load, then kexp_ready after lat cycles
  task automatic keygen(input int lat);
    cyc(0, 1, 0, 0, 0);
    chk("kg_start", bus.kexp_start_o, 1);
    chk("kg_start_noreject", bus.key_reject_o, 0);
    for (int i = 1; i <= lat; i++) begin
      cyc(0, 0, 0, (i == lat), 0);
      chk("kg_start_single", bus.kexp_start_o, 0);
      chk("kg_key_valid_low", bus.key_valid_o, 0);
      chk("kg_text_ready_low", bus.text_ready_o, 0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("kg_key_valid", bus.key_valid_o, 1);
    chk("kg_text_ready", bus.text_ready_o, 1);
  endtask

  // One block: out_ready held low for hold cycles in OUT; key_load at round rej
  task automatic run_block(input int hold, input int rej);
    cyc(0, 0, 1, 0, 1);
    chk("blk_dp_load", bus.dp_load_o, 1);
    chk("blk_load_round0", bus.round_num_o, 0);
    chk("blk_load_no_en", bus.dp_en_o, 0);
    chk("blk_text_ready", bus.text_ready_o, 1);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, (i == rej), 1, 0, 1);
      chk("rnd_dp_en", bus.dp_en_o, 1);
      chk("rnd_no_load", bus.dp_load_o, 0);
      chk("rnd_num", bus.round_num_o, i);
      chk("rnd_last", bus.dp_last_o, (i == 10));
      chk("rnd_reject", bus.key_reject_o, (i == rej));
      chk("rnd_text_ready", bus.text_ready_o, 0);
      chk("rnd_out_valid", bus.out_valid_o, 0);
      chk("rnd_key_valid", bus.key_valid_o, 1);
    end
    for (int k = 0; k <= hold; k++) begin
      cyc(0, 0, 1, 0, (k == hold));
      chk("out_valid", bus.out_valid_o, 1);
      chk("out_text_ready", bus.text_ready_o, 0);
      chk("out_no_load", bus.dp_load_o, 0);
      chk("out_no_en", bus.dp_en_o, 0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("post_out_valid", bus.out_valid_o, 0);
    chk("post_text_ready", bus.text_ready_o, 1);
  endtask

  initial begin
    bus.key_load_i   = 1'b0;
    bus.text_valid_i = 1'b0;
    bus.kexp_ready_i = 1'b0;
    bus.out_ready_i  = 1'b0;

    // Reset holds every output low even with all inputs active
    cyc(1, 1, 1, 1, 1);
    chk("rst_outs", 32'(outs()), 0);
    cyc(1, 1, 1, 1, 1);
    chk("rst_outs", 32'(outs()), 0);

    // No text acceptance before a key has been loaded
    cyc(0, 0, 1, 1, 0);
    chk("idle_text_ready", bus.text_ready_o, 0);
    chk("idle_no_load", bus.dp_load_o, 0);
    chk("idle_key_valid", bus.key_valid_o, 0);
    cyc(0, 0, 0, 0, 0);
    chk("idle_kready_ignored", bus.key_valid_o, 0);

    keygen(10);

    run_block(0, 0);   // straight-through block
    run_block(5, 0);   // downstream stalls 5 cycles
    run_block(0, 4);   // key load rejected at round 4

    // Key load and text together in READY: key wins
    cyc(0, 1, 1, 0, 0);
    chk("coll_text_ready", bus.text_ready_o, 0);
    chk("coll_no_load", bus.dp_load_o, 0);
    chk("coll_start", bus.kexp_start_o, 1);
    chk("coll_no_reject", bus.key_reject_o, 0);
    cyc(0, 1, 0, 0, 0);
    chk("kg_reject", bus.key_reject_o, 1);
    chk("kg_reject_no_start", bus.kexp_start_o, 0);
    chk("kg_key_valid_clear", bus.key_valid_o, 0);
    chk("kg_no_en", bus.dp_en_o, 0);
    cyc(0, 0, 1, 1, 0);
    chk("kg_text_ignored", bus.dp_load_o, 0);
    chk("kg_reject_once", bus.key_reject_o, 0);
    cyc(0, 0, 0, 0, 0);
    chk("coll_key_valid", bus.key_valid_o, 1);
    chk("coll_text_ready_back", bus.text_ready_o, 1);

    // Key expansion timeout
    cyc(0, 1, 0, 0, 0);
    chk("tmo_start", bus.kexp_start_o, 1);
    for (int i = 1; i <= 15; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("tmo_err_low", bus.err_o, 0);
    end
    cyc(0, 0, 1, 1, 0);
    chk("tmo_err", bus.err_o, 1);
    chk("tmo_idle_text_ready", bus.text_ready_o, 0);
    chk("tmo_key_valid", bus.key_valid_o, 0);
    cyc(0, 0, 0, 0, 0);
    chk("tmo_kready_ignored", bus.key_valid_o, 0);
    chk("tmo_err_sticky", bus.err_o, 1);
    cyc(0, 1, 0, 0, 0);
    chk("tmo_restart", bus.kexp_start_o, 1);
    chk("tmo_err_until_load", bus.err_o, 1);
    cyc(0, 0, 0, 1, 0);
    chk("tmo_err_cleared", bus.err_o, 0);
    cyc(0, 0, 0, 0, 0);
    chk("tmo_recover_key_valid", bus.key_valid_o, 1);
    chk("tmo_recover_text_ready", bus.text_ready_o, 1);

    // Reset in the middle of a block
    cyc(0, 0, 1, 0, 1);
    chk("mid_dp_load", bus.dp_load_o, 1);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk("mid_round", bus.round_num_o, i);
    end
    cyc(1, 0, 0, 0, 1);
    chk("mid_rst_outs", 32'(outs()), 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1, 0, 1);
      chk("post_rst_outs", 32'(outs()), 0);
    end

    // Normal operation resumes after a fresh key load
    keygen(3);
    run_block(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_dec_ctrl.md
AES_DEC_CTRL -- requirements
Module: aes_dec_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, the number of cipher rounds after the initial AddRoundKey.
REQ-002 SHALL have parameter KEYGEN_TIMEOUT, default 15, the maximum number of cycles to wait for kexp_ready_i.
REQ-003 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 key_load_i  input  1  one-cycle request to expand the key currently presented to the key expansion.
REQ-006 kexp_start_o  output  1  one-cycle pulse that starts the key expansion.
REQ-007 kexp_ready_i  input  1  key expansion reports that all round keys are stored.
REQ-008 text_valid_i  input  1  ciphertext block is offered.
REQ-009 text_ready_o  output  1  controller accepts the ciphertext block.
REQ-010 dp_load_o  output  1  datapath loads the ciphertext and applies the first round key.
REQ-011 dp_en_o  output  1  datapath executes one inverse round.
REQ-012 dp_last_o  output  1  current round is the final round, with InvMixColumns bypassed.
REQ-013 round_num_o  output  4  round index driven to the key store.
REQ-014 out_valid_o  output  1  plaintext is valid on the datapath output.
REQ-015 out_ready_i  input  1  downstream accepts the plaintext.
REQ-016 key_valid_o  output  1  round keys are usable.
REQ-017 key_reject_o  output  1  one-cycle pulse: key_load_i was ignored.
REQ-018 err_o  output  1  sticky key-expansion timeout flag.

Function
REQ-019 SHALL implement the states IDLE, KEYGEN, READY, ROUND and OUT.
REQ-020 In IDLE or READY, key_load_i SHALL move the FSM to KEYGEN, drive kexp_start_o in that same cycle, and clear key_valid_o and the timeout counter.
REQ-021 In KEYGEN, kexp_ready_i=1 SHALL move the FSM to READY, with key_valid_o=1 from the next cycle.
REQ-022 In KEYGEN, KEYGEN_TIMEOUT cycles without kexp_ready_i SHALL set err_o and move the FSM to IDLE.
REQ-023 err_o SHALL clear only on reset or on the next key_load_i.
REQ-024 text_ready_o SHALL equal (state==READY) AND NOT key_load_i, combinationally.
REQ-025 When key_load_i and text_valid_i are high together in READY, the key load SHALL win and the text SHALL NOT be accepted.
REQ-026 A handshake (text_valid_i AND text_ready_o) at cycle T SHALL assert dp_load_o in cycle T with round_num_o=0, and move the FSM to ROUND.
REQ-027 In ROUND, the FSM SHALL assert dp_en_o with round_num_o = 1..NUM_ROUNDS on consecutive cycles T+1..T+NUM_ROUNDS.
REQ-028 dp_last_o SHALL be high only while round_num_o==NUM_ROUNDS.
REQ-029 After round NUM_ROUNDS, the FSM SHALL enter OUT, with out_valid_o high from cycle T+NUM_ROUNDS+1 (default T+11).
REQ-030 out_valid_o SHALL hold until out_ready_i; the FSM SHALL then return to READY in the next cycle, with out_valid_o low.
REQ-031 The minimum spacing between accepted blocks SHALL be NUM_ROUNDS+2 cycles.
REQ-032 key_load_i in KEYGEN, ROUND or OUT SHALL be ignored and SHALL pulse key_reject_o for one cycle; the current operation continues unchanged.
REQ-033 text_valid_i outside READY SHALL have no effect.
REQ-034 The round counter SHALL be 4 bits, SHALL count only in ROUND, and SHALL reset to 0 on every transition into ROUND; it never wraps.
REQ-035 kexp_ready_i SHALL be ignored outside KEYGEN.
REQ-036 dp_load_o and dp_en_o SHALL never be high in the same cycle.

Reset
REQ-037 rst_i=1 at any clock edge SHALL force state IDLE, round counter 0 and timeout counter 0.
REQ-038 rst_i=1 SHALL force every output to 0, including key_valid_o and err_o.
REQ-039 Reset during ROUND or OUT SHALL abandon the block with no out_valid_o.
REQ-040 After reset, a new key_load_i SHALL be required before text_ready_o can assert.

Verification
REQ-041 Reset, then key_load_i; kexp_ready_i 10 cycles later -> kexp_start_o one pulse, key_valid_o=1 on the 11th cycle, text_ready_o=1.
REQ-042 Accept text at T, with out_ready_i=1 -> dp_load_o at T; dp_en_o at T+1..T+10 with round_num_o 1..10; dp_last_o only at T+10; out_valid_o at T+11; text_ready_o again at T+12.
REQ-043 Hold out_ready_i=0 for 5 cycles in OUT -> out_valid_o stays high for 6 cycles; a new text_valid_i is not accepted in that time.
REQ-044 key_load_i at round 4, and key_load_i together with text_valid_i in READY -> key_reject_o pulses and the rounds complete normally; in READY, KEYGEN is entered and the text is not accepted.
REQ-045 Withhold kexp_ready_i -> err_o=1 and IDLE after 15 cycles; a following key_load_i clears err_o.
REQ-046 Assert rst_i at round 6 -> all outputs are 0 next cycle, no out_valid_o, and key_valid_o=0.
